uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Sits downstream of the UART byte receiver and turns the serial byte stream into camera-register commands.
//  - Frames fixed 6-byte packets and checks an XOR checksum.
//  - Presents each accepted command to the register-access master (sensor config bus) via valid/ready.
//  - Keeps saturating error/drop counters for debug readout.
// PARAMETERS
//  SYNC_BYTE       8'hA5  first byte of every frame
//  TIMEOUT_CYCLES  4096   idle cycles between bytes before a partial frame is discarded (CMD_TIMEOUT_EN only)
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   reset, synchronous, active-high
//  RX_DATA    in   8   received byte; stable while RX_READY high
//  RX_READY   in   1   byte-done level from receiver; rises once per byte, may stay high for many cycles
//  CMD_VALID  out  1   command available
//  CMD_READY  in   1   consumer accepts command when CMD_VALID & CMD_READY
//  CMD_WRITE  out  1   1 = register write, 0 = register read
//  CMD_ADDR   out  8   register address
//  CMD_DATA   out  16  write data ({DATA_H, DATA_L}); don't-care for reads
//  ERR_CNT    out  8   saturating count of rejected frames (bad checksum, bad opcode, timeout)
//  DROP_CNT   out  8   saturating count of bytes discarded while a command waits in HOLD
// BEHAVIOUR
//  - Frame: SYNC, OPC, ADDR, DATA_H, DATA_L, CHK.
//    OPC: 8'h01 = write, 8'h02 = read. CHK = OPC^ADDR^DATA_H^DATA_L.
//  - Byte strobe: stb = RX_READY & ~rdy_q, where rdy_q is RX_READY registered.
//    Reset sets rdy_q=1, so a level already high at reset release is not a byte.
//  - All outputs reset to 0. The FSM resets to IDLE; the checksum accumulator resets to 0.
//  - FSM, advancing only on stb:
//    IDLE: byte==SYNC_BYTE -> OPC, else stay (byte silently ignored).
//    OPC: 01/02 -> ADDR, latch CMD_WRITE; any other value -> IDLE, ERR_CNT++.
//    ADDR -> DH -> DL -> CHK, latching fields and accumulating XOR.
//    CHK: match -> HOLD, CMD_VALID=1 from the next cycle (one-cycle latency after the CHK stb);
//      mismatch -> IDLE, ERR_CNT++.
//    HOLD: CMD_VALID & CMD_FIELDS held stable until CMD_READY. On handshake: CMD_VALID=0 next cycle, -> IDLE.
//  - stb while in HOLD: byte dropped, DROP_CNT++. A stb in the same cycle as the handshake is also dropped.
//    A SYNC byte in HOLD does not start a frame.
//  - SYNC value inside OPC..CHK is treated as ordinary payload (no mid-frame resync).
//  - ERR_CNT and DROP_CNT saturate at 8'hFF and clear only on RST.
//  - RST mid-frame or in HOLD: partial frame and pending command discarded; counters cleared.
//  - CMD_READY while CMD_VALID=0 has no effect.
// CONFIGURATION
//  - CMD_TIMEOUT_EN defined: 16-bit idle counter.
//    - Cleared on every stb and whenever the FSM is in IDLE or HOLD.
//    - Counts while in OPC..CHK. On reaching TIMEOUT_CYCLES: -> IDLE, ERR_CNT++, accumulator cleared.
//    - A stb in the same cycle as the timeout wins: the byte is processed and no timeout occurs.
//  - CMD_TIMEOUT_EN undefined: no counter; a partial frame waits indefinitely.
// STRUCTURE
//  - Shared include uart_cmd_defs.vh: SYNC default, OPC_WRITE/OPC_READ, FSM state encodings, FRAME_LEN=6.
//    The register-access master uses the same include.
//  - One sub-module, sat_counter8 (enable-increment, saturate at 255, sync clear), instantiated for ERR_CNT and DROP_CNT.
//  - FSM, field registers and timeout stay in this module.
// TESTING
//  - Frame A5 01 20 12 34 07, CMD_READY=1 -> one-cycle CMD_VALID; WRITE=1, ADDR=20, DATA=1234; ERR_CNT=0.
//  - Frame A5 01 20 12 34 00 (bad CHK) -> no CMD_VALID; ERR_CNT=1; next good frame still accepted.
//  - Good read frame A5 02 0F 00 00 0D, CMD_READY=0 for 2000 cycles while 3 bytes arrive:
//    CMD_VALID held, fields stable, DROP_CNT=3; after READY, FSM back in IDLE.
//  - Frame A5 7F ...: ERR_CNT=1 after the OPC byte. RX_READY held high 500 cycles: exactly one stb per rising edge.
//  - RST asserted after A5 01 20 -> outputs 0. Then 20 12 34 07 alone -> no command.
//    RX_READY=1 through reset release -> no stb.
//  - CMD_TIMEOUT_EN, TIMEOUT_CYCLES=64: A5 01 then 64 idle cycles -> IDLE, ERR_CNT=1.
//    With the next byte at idle cycle 63 the frame continues. Without the macro the frame completes after any gap.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser and the register-access master:
// sync byte default, opcodes, frame length and FSM state encoding.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] OPC_WRITE    = 8'h01;
  localparam logic [7:0] OPC_READ     = 8'h02;
  localparam int         FRAME_LEN    = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPC  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DH   = 3'd3,
    ST_DL   = 3'd4,
    ST_CHK  = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  function automatic logic opc_valid(input logic [7:0] opc);
    return (opc == OPC_WRITE) || (opc == OPC_READ);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_sat_counter8.sv
// 8-bit event counter that sticks at 8'hFF; cleared only by the synchronous reset.
module sat_counter8 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge CLK) begin
    if (RST)
      count <= 8'h00;
    else if (inc && (count != 8'hFF))
      count <= count + 8'h01;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames 6-byte XOR-checked packets from the UART receiver into register commands.
// Optional partial-frame timeout is built when CMD_TIMEOUT_EN is defined.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
`ifdef CMD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_READY,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic        CMD_WRITE,
  output logic [7:0]  CMD_ADDR,
  output logic [15:0] CMD_DATA,
  output logic [7:0]  ERR_CNT,
  output logic [7:0]  DROP_CNT
);

  state_t     state, state_nxt;
  logic       rdy_q;
  logic       stb;
  logic [7:0] acc;
  logic [7:0] data_h, data_l;
  logic       err_inc, drop_inc;
  logic       in_frame;
  logic       timeout;

  // rdy_q starts high so a level already asserted at reset release is not a byte
  always_ff @(posedge CLK) begin
    if (RST)
      rdy_q <= 1'b1;
    else
      rdy_q <= RX_READY;
  end

  assign stb      = RX_READY & ~rdy_q;
  assign in_frame = (state != ST_IDLE) && (state != ST_HOLD);

`ifdef CMD_TIMEOUT_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge CLK) begin
    if (RST || stb || !in_frame)
      idle_cnt <= 16'h0000;
    else
      idle_cnt <= idle_cnt + 16'h0001;
  end

  // A strobe in the expiry cycle keeps the frame alive
  assign timeout = in_frame && !stb && (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (stb && (RX_DATA == SYNC_BYTE)) state_nxt = ST_OPC;
      ST_OPC:  if (stb) state_nxt = opc_valid(RX_DATA) ? ST_ADDR : ST_IDLE;
      ST_ADDR: if (stb) state_nxt = ST_DH;
      ST_DH:   if (stb) state_nxt = ST_DL;
      ST_DL:   if (stb) state_nxt = ST_CHK;
      ST_CHK:  if (stb) state_nxt = (RX_DATA == acc) ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (CMD_READY) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout)
      state_nxt = ST_IDLE;
  end

  always_comb begin
    CMD_VALID = (state == ST_HOLD);
    drop_inc  = stb && (state == ST_HOLD);
    err_inc   = timeout
              || (stb && (state == ST_OPC) && !opc_valid(RX_DATA))
              || (stb && (state == ST_CHK) && (RX_DATA != acc));
  end

  // Field capture and running checksum; the fields only move while no command is pending
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc       <= 8'h00;
      CMD_WRITE <= 1'b0;
      CMD_ADDR  <= 8'h00;
      data_h    <= 8'h00;
      data_l    <= 8'h00;
    end else if (timeout) begin
      acc <= 8'h00;
    end else if (stb) begin
      unique case (state)
        ST_IDLE: acc <= 8'h00;
        ST_OPC: begin
          acc <= RX_DATA;
          if (opc_valid(RX_DATA))
            CMD_WRITE <= (RX_DATA == OPC_WRITE);
        end
        ST_ADDR: begin
          acc      <= acc ^ RX_DATA;
          CMD_ADDR <= RX_DATA;
        end
        ST_DH: begin
          acc    <= acc ^ RX_DATA;
          data_h <= RX_DATA;
        end
        ST_DL: begin
          acc    <= acc ^ RX_DATA;
          data_l <= RX_DATA;
        end
        default: ;
      endcase
    end
  end

  assign CMD_DATA = {data_h, data_l};

  sat_counter8 u_err_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (err_inc),
    .count (ERR_CNT)
  );

  sat_counter8 u_drop_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (drop_inc),
    .count (DROP_CNT)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser; the timeout section is selected by CMD_TIMEOUT_EN.
module tb_uart_cmd_parser;
  import uart_cmd_parser_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_READY;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [7:0]  CMD_ADDR;
  logic [15:0] CMD_DATA;
  logic [7:0]  ERR_CNT;
  logic [7:0]  DROP_CNT;

  int checks   = 0;
  int failures = 0;

  int          hs_count  = 0;
  int          vcycles   = 0;
  int          unstable  = 0;
  logic        hs_write  = 1'b0;
  logic [7:0]  hs_addr   = 8'h00;
  logic [15:0] hs_data   = 16'h0000;
  logic        prev_valid = 1'b0;
  logic [24:0] prev_fields = '0;

  int hs0, vc0;

  always #5 CLK = ~CLK;

`ifdef CMD_TIMEOUT_EN
  uart_cmd_parser #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .ERR_CNT(ERR_CNT), .DROP_CNT(DROP_CNT)
  );
`else
  uart_cmd_parser dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .ERR_CNT(ERR_CNT), .DROP_CNT(DROP_CNT)
  );
`endif

  // Handshake monitor: samples a little after each falling edge, well before the next rising edge
  always begin
    @(negedge CLK);
    #2;
    if (CMD_VALID && prev_valid && ({CMD_WRITE, CMD_ADDR, CMD_DATA} != prev_fields))
      unstable++;
    prev_valid  = CMD_VALID;
    prev_fields = {CMD_WRITE, CMD_ADDR, CMD_DATA};
    if (CMD_VALID)
      vcycles++;
    if (CMD_VALID && CMD_READY) begin
      hs_count++;
      hs_write = CMD_WRITE;
      hs_addr  = CMD_ADDR;
      hs_data  = CMD_DATA;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one byte with RX_READY high for 'hold' cycles, then low for one cycle
  task automatic applyStimulus(input logic [7:0] b, input int hold);
    RX_DATA  = b;
    RX_READY = 1'b1;
    repeat (hold) @(negedge CLK);
    RX_READY = 1'b0;
    @(negedge CLK);
  endtask

  task automatic sendFrame(input logic [47:0] f);
    for (int i = 0; i < FRAME_LEN; i++)
      applyStimulus(f[47 - 8*i -: 8], 1);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST       = 1'b1;
    RX_DATA   = 8'h00;
    RX_READY  = 1'b0;
    CMD_READY = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("reset_valid", {31'd0, CMD_VALID}, 32'd0);
    checkOutput("reset_addr",  {24'd0, CMD_ADDR}, 32'd0);
    checkOutput("reset_err",   {24'd0, ERR_CNT}, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Good write frame, consumer always ready
    hs0 = hs_count; vc0 = vcycles;
    sendFrame(48'hA5_01_20_12_34_07);
    checkOutput("t1_hs",     hs_count - hs0, 1);
    checkOutput("t1_vcyc",   vcycles - vc0, 1);
    checkOutput("t1_write",  {31'd0, hs_write}, 32'd1);
    checkOutput("t1_addr",   {24'd0, hs_addr}, 32'h20);
    checkOutput("t1_data",   {16'd0, hs_data}, 32'h1234);
    checkOutput("t1_err",    {24'd0, ERR_CNT}, 32'd0);

    // Bad checksum, then a good frame
    hs0 = hs_count;
    sendFrame(48'hA5_01_20_12_34_00);
    checkOutput("t2_hs",     hs_count - hs0, 0);
    checkOutput("t2_err",    {24'd0, ERR_CNT}, 32'd1);
    sendFrame(48'hA5_01_55_AA_0F_F1);
    checkOutput("t2_hs_good", hs_count - hs0, 1);
    checkOutput("t2_addr",   {24'd0, hs_addr}, 32'h55);
    checkOutput("t2_data",   {16'd0, hs_data}, 32'hAA0F);

    // Read frame held in HOLD while bytes arrive and are dropped
    hs0 = hs_count;
    CMD_READY = 1'b0;
    sendFrame(48'hA5_02_0F_00_00_0D);
    repeat (600) @(negedge CLK);
    applyStimulus(8'hA5, 1);
    repeat (600) @(negedge CLK);
    applyStimulus(8'h33, 1);
    repeat (600) @(negedge CLK);
    applyStimulus(8'h44, 1);
    repeat (190) @(negedge CLK);
    checkOutput("t3_valid",  {31'd0, CMD_VALID}, 32'd1);
    checkOutput("t3_write",  {31'd0, CMD_WRITE}, 32'd0);
    checkOutput("t3_addr",   {24'd0, CMD_ADDR}, 32'h0F);
    checkOutput("t3_drop",   {24'd0, DROP_CNT}, 32'd3);
    checkOutput("t3_hs_wait", hs_count - hs0, 0);
    CMD_READY = 1'b1;
    @(negedge CLK);
    checkOutput("t3_valid_off", {31'd0, CMD_VALID}, 32'd0);
    checkOutput("t3_hs",     hs_count - hs0, 1);
    checkOutput("t3_hs_addr", {24'd0, hs_addr}, 32'h0F);
    checkOutput("t3_stable", unstable, 0);
    sendFrame(48'hA5_01_55_AA_0F_F1);
    checkOutput("t3_idle_again", hs_count - hs0, 2);
    checkOutput("t3_drop_kept", {24'd0, DROP_CNT}, 32'd3);

    // Bad opcode, then a frame with long RX_READY levels
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h7F, 1);
    checkOutput("t4_err",    {24'd0, ERR_CNT}, 32'd2);
    hs0 = hs_count;
    applyStimulus(8'hA5, 500);
    applyStimulus(8'h01, 500);
    applyStimulus(8'h3C, 1);
    applyStimulus(8'h56, 1);
    applyStimulus(8'h78, 1);
    applyStimulus(8'h13, 1);
    repeat (2) @(negedge CLK);
    checkOutput("t4_hs",     hs_count - hs0, 1);
    checkOutput("t4_addr",   {24'd0, hs_addr}, 32'h3C);
    checkOutput("t4_data",   {16'd0, hs_data}, 32'h5678);
    checkOutput("t4_err_kept", {24'd0, ERR_CNT}, 32'd2);

    // Reset mid-frame with RX_READY high through the release
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h20, 1);
    RX_DATA  = 8'hA5;
    RX_READY = 1'b1;
    RST      = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("t5_valid",  {31'd0, CMD_VALID}, 32'd0);
    checkOutput("t5_write",  {31'd0, CMD_WRITE}, 32'd0);
    checkOutput("t5_fields", {8'd0, CMD_ADDR, CMD_DATA}, 32'd0);
    checkOutput("t5_cnts",   {16'd0, ERR_CNT, DROP_CNT}, 32'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    RX_READY = 1'b0;
    @(negedge CLK);
    hs0 = hs_count;
    applyStimulus(8'h20, 1);
    applyStimulus(8'h12, 1);
    applyStimulus(8'h34, 1);
    applyStimulus(8'h07, 1);
    repeat (3) @(negedge CLK);
    checkOutput("t5_no_cmd", hs_count - hs0, 0);
    checkOutput("t5_err",    {24'd0, ERR_CNT}, 32'd0);
    sendFrame(48'hA5_01_20_12_34_07);
    checkOutput("t5_alive",  hs_count - hs0, 1);

`ifdef CMD_TIMEOUT_EN
    // 64 idle cycles after OPC abandons the frame
    hs0 = hs_count;
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h01, 1);
    repeat (70) @(negedge CLK);
    checkOutput("t6_timeout_err", {24'd0, ERR_CNT}, 32'd1);
    // Next byte at idle cycle 63 keeps the frame alive
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h01, 1);
    repeat (61) @(negedge CLK);
    applyStimulus(8'h20, 1);
    applyStimulus(8'h12, 1);
    applyStimulus(8'h34, 1);
    applyStimulus(8'h07, 1);
    repeat (2) @(negedge CLK);
    checkOutput("t6_hs",     hs_count - hs0, 1);
    checkOutput("t6_err_kept", {24'd0, ERR_CNT}, 32'd1);
`else
    // Without the timeout a long gap does not break the frame
    hs0 = hs_count;
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h01, 1);
    repeat (5000) @(negedge CLK);
    applyStimulus(8'h20, 1);
    applyStimulus(8'h12, 1);
    applyStimulus(8'h34, 1);
    applyStimulus(8'h07, 1);
    repeat (2) @(negedge CLK);
    checkOutput("t6_gap_hs", hs_count - hs0, 1);
    checkOutput("t6_gap_err", {24'd0, ERR_CNT}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
